// File: rtl/game_flow_if.sv
// Operator-key inputs and scoreboard-facing outputs of the game sequencer.
// Handshake: every *_p input and score_we/buzzer are single-cycle strobes, no back-pressure.
interface game_flow_if;
   logic       start_p;
   logic       pause_p;
   logic       score_p;
   logic       team_sel;
   logic [1:0] pts;
   logic       poss_sw_p;
   logic [2:0] state;
   logic       poss;
   logic [6:0] game_clk;
   logic [4:0] shot_clk;
   logic [3:0] rest_clk;
   logic [1:0] quarter;
   logic       score_we;
   logic       score_team;
   logic [1:0] score_pts;
   logic       buzzer;

   modport master (
      output start_p, pause_p, score_p, team_sel, pts, poss_sw_p,
      input  state, poss, game_clk, shot_clk, rest_clk, quarter,
             score_we, score_team, score_pts, buzzer
   );

   modport slave (
      input  start_p, pause_p, score_p, team_sel, pts, poss_sw_p,
      output state, poss, game_clk, shot_clk, rest_clk, quarter,
             score_we, score_team, score_pts, buzzer
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// Basketball game sequencer: 1 s prescaler, quarter/break/shot clocks,
// possession and registered score-commit strobes.
module game_flow_ctrl #(
   parameter int COUNT_1S  = 12048193,
   parameter int QUARTER_S = 60,
   parameter int REST_S    = 10,
   parameter int SHOT_S    = 24,
   parameter int NUM_QTR   = 4
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   game_flow_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_PAUSE = 3'd2,
      ST_BREAK = 3'd3,
      ST_FINAL = 3'd4
   } state_e;

   localparam int            PW       = (COUNT_1S > 1) ? $clog2(COUNT_1S) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(COUNT_1S - 1);
   localparam logic [6:0]    GAME_RLD = 7'(QUARTER_S);
   localparam logic [4:0]    SHOT_RLD = 5'(SHOT_S);
   localparam logic [3:0]    REST_RLD = 4'(REST_S);
   localparam logic [1:0]    LAST_QTR = 2'(NUM_QTR - 1);

   state_e        state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          poss_q, poss_d;
   logic [6:0]    game_q, game_d;
   logic [4:0]    shot_q, shot_d;
   logic [3:0]    rest_q, rest_d;
   logic [1:0]    qtr_q, qtr_d;
   logic          we_q, we_d;
   logic          team_q, team_d;
   logic [1:0]    pts_q, pts_d;
   logic          buzz_q, buzz_d;
   logic          counting;
   logic          tick;
   logic          score_ok;

   always_comb begin
      state_d  = state_q;
      pre_d    = pre_q;
      poss_d   = poss_q;
      game_d   = game_q;
      shot_d   = shot_q;
      rest_d   = rest_q;
      qtr_d    = qtr_q;
      we_d     = 1'b0;
      team_d   = team_q;
      pts_d    = pts_q;
      buzz_d   = 1'b0;
      counting = (state_q == ST_RUN) || (state_q == ST_BREAK);
      tick     = counting && (pre_q == PRE_LAST);
      score_ok = bus.score_p && (bus.pts != 2'd0);

      if (counting) pre_d = tick ? '0 : pre_q + 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (bus.start_p) begin
               state_d = ST_RUN;
               pre_d   = '0;
            end
         end
         ST_RUN, ST_PAUSE: begin
            if (state_q == ST_RUN && tick) begin
               game_d = game_q - 7'd1;
               // Quarter end outranks a coincident shot-clock violation.
               if (game_q == 7'd1) begin
                  buzz_d = 1'b1;
                  shot_d = SHOT_RLD;
                  if (qtr_q == LAST_QTR) begin
                     state_d = ST_FINAL;
                  end else begin
                     state_d = ST_BREAK;
                     rest_d  = REST_RLD;
                  end
               end else if (shot_q == 5'd1) begin
                  buzz_d = 1'b1;
                  poss_d = ~poss_q;
                  shot_d = SHOT_RLD;
               end else begin
                  shot_d = shot_q - 5'd1;
               end
            end
            // Operator reloads override whatever the tick did to poss/shot.
            if (score_ok) begin
               we_d   = 1'b1;
               team_d = bus.team_sel;
               pts_d  = bus.pts;
               poss_d = ~bus.team_sel;
               shot_d = SHOT_RLD;
            end else if (bus.poss_sw_p) begin
               poss_d = ~poss_q;
               shot_d = SHOT_RLD;
            end
            if (state_q == ST_RUN && bus.pause_p && state_d == ST_RUN) state_d = ST_PAUSE;
            if (state_q == ST_PAUSE && bus.start_p) state_d = ST_RUN;
         end
         ST_BREAK: begin
            if (tick) begin
               rest_d = rest_q - 4'd1;
               if (rest_q == 4'd1) begin
                  qtr_d   = qtr_q + 2'd1;
                  game_d  = GAME_RLD;
                  shot_d  = SHOT_RLD;
                  rest_d  = 4'd0;
                  poss_d  = ~qtr_q[0];
                  state_d = ST_RUN;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
         pre_q   <= '0;
         poss_q  <= 1'b0;
         game_q  <= GAME_RLD;
         shot_q  <= SHOT_RLD;
         rest_q  <= 4'd0;
         qtr_q   <= 2'd0;
         we_q    <= 1'b0;
         team_q  <= 1'b0;
         pts_q   <= 2'd0;
         buzz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         poss_q  <= poss_d;
         game_q  <= game_d;
         shot_q  <= shot_d;
         rest_q  <= rest_d;
         qtr_q   <= qtr_d;
         we_q    <= we_d;
         team_q  <= team_d;
         pts_q   <= pts_d;
         buzz_q  <= buzz_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.poss       = poss_q;
   assign bus.game_clk   = game_q;
   assign bus.shot_clk   = shot_q;
   assign bus.rest_clk   = rest_q;
   assign bus.quarter    = qtr_q;
   assign bus.score_we   = we_q;
   assign bus.score_team = team_q;
   assign bus.score_pts  = pts_q;
   assign bus.buzzer     = buzz_q;
endmodule
